// File: rtl/alu_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// alu_ctrl_sequencer
//   Instruction-issue/control sequencer for the regfile+ALU datapath. Accepts
//   RV32I ALU instructions (R-type and I-type) over a valid/ready handshake,
//   decodes them, and drives the datapath's instruction, ALU_Control, op_B_sel
//   and wEn inputs. Sequence per instruction: IDLE -> DECODE -> EXEC.
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   asynchronous, active-high
//   instr_valid    in   upstream presents instr_in
//   instr_ready    out  sequencer accepts instr_in this cycle (IDLE/EXEC)
//   instr_in       in   RV32I instruction word
//   instruction    out  registered instruction to datapath
//   ALU_Control    out  ALU operation select {0.., b30, funct3}
//   op_B_sel       out  0 = rs2 operand, 1 = I-immediate
//   wEn            out  regfile write enable, high only in EXEC with rd != 0
//   illegal        out  1-cycle pulse in DECODE for an unsupported opcode
//   busy           out  state != IDLE
//   retired_count  out  committed writes (only with CTRL_RETIRE_CNT_EN)
//
// Optional feature macro: CTRL_RETIRE_CNT_EN adds the retired_count port and
// its wrapping counter. Undefined by default.
// ---------------------------------------------------------------------------
module alu_ctrl_sequencer #(
    parameter int CTRL_WIDTH = 6
`ifdef CTRL_RETIRE_CNT_EN
    , parameter int CNT_WIDTH = 16
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr_in,
    output logic [31:0]           instruction,
    output logic [CTRL_WIDTH-1:0] ALU_Control,
    output logic                  op_B_sel,
    output logic                  wEn,
    output logic                  illegal,
    output logic                  busy
`ifdef CTRL_RETIRE_CNT_EN
    , output logic [CNT_WIDTH-1:0] retired_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2
    } state_t;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    state_t                  state_q;
    logic [31:0]             instr_q;
    logic [CTRL_WIDTH-1:0]   ctrl_q;
    logic                    opb_q;
    logic                    wen_q;
    logic                    illegal_q;
    logic                    busy_q;
    logic                    ready_q;
`ifdef CTRL_RETIRE_CNT_EN
    logic [CNT_WIDTH-1:0]    cnt_q;
`endif

    logic                    dec_legal;
    logic [CTRL_WIDTH-1:0]   dec_ctrl;
    logic                    dec_opb;
    logic                    accept;

    // Combinational decode of the word being offered; captured on accept.
    always_comb begin
        dec_legal = 1'b0;
        dec_ctrl  = '0;
        dec_opb   = 1'b0;
        case (instr_in[6:0])
            OPC_R: begin
                dec_legal     = 1'b1;
                dec_ctrl[3:0] = {instr_in[30], instr_in[14:12]};
            end
            OPC_I: begin
                dec_legal     = 1'b1;
                dec_opb       = 1'b1;
                // b30 is an immediate bit except for the SRLI/SRAI shift pair
                dec_ctrl[3:0] = {(instr_in[14:12] == 3'b101) ? instr_in[30] : 1'b0,
                                 instr_in[14:12]};
            end
            default: ;
        endcase
    end

    // ready_q is low in DECODE, so this only fires in IDLE or EXEC.
    assign accept = instr_valid & ready_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            ctrl_q    <= '0;
            opb_q     <= 1'b0;
            wen_q     <= 1'b0;
            illegal_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
`ifdef CTRL_RETIRE_CNT_EN
            cnt_q     <= '0;
`endif
        end else begin
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                DECODE: begin
                    ready_q <= 1'b1;
                    if (illegal_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= EXEC;
                        wen_q   <= (instr_q[11:7] != 5'd0);
                    end
                end
                EXEC: begin
                    wen_q   <= 1'b0;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
`ifdef CTRL_RETIRE_CNT_EN
                    if (wen_q) cnt_q <= cnt_q + 1'b1;
`endif
                end
                default: begin
                    state_q <= IDLE;
                    wen_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
            // A handshake in IDLE or EXEC overrides the next-state chosen above.
            if (accept) begin
                state_q   <= DECODE;
                instr_q   <= instr_in;
                ctrl_q    <= dec_ctrl;
                opb_q     <= dec_opb;
                illegal_q <= ~dec_legal;
                busy_q    <= 1'b1;
                ready_q   <= 1'b0;
            end
        end
    end

    assign instruction = instr_q;
    assign ALU_Control = ctrl_q;
    assign op_B_sel    = opb_q;
    assign wEn         = wen_q;
    assign illegal     = illegal_q;
    assign busy        = busy_q;
    assign instr_ready = ready_q;
`ifdef CTRL_RETIRE_CNT_EN
    assign retired_count = cnt_q;
`endif

endmodule
